// File: rtl/gnr_cycle_ctrl.sv
// gnr_cycle_ctrl: loads a dual-trajectory Boolean-network array, steps it, and finds the attractor with Floyd detection
module gnr_cycle_ctrl #(
   parameter int NUM_NODES = 8,
   parameter int STEP_W    = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 abort,
   input  logic [NUM_NODES-1:0] init_value,
   input  logic [STEP_W-1:0]    max_steps,
   input  logic [NUM_NODES-1:0] s0_vec,
   input  logic [NUM_NODES-1:0] s1_vec,
   output logic                 reset_nos,
   output logic [NUM_NODES-1:0] init_state,
   output logic                 start_s0,
   output logic                 start_s1,
   output logic                 busy,
   output logic                 done,
   output logic                 found,
   output logic [STEP_W-1:0]    meet_step,
   output logic [STEP_W-1:0]    period
);
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STEP, S_CHECK, S_PSTEP, S_PCHECK, S_DONE} state_t;
   state_t state, nxt;
   logic [STEP_W-1:0] step_cnt, period_cnt, max_q;
   logic same;
   assign same = s0_vec == s1_vec;
   // next state; abort overrides every transition, equality on the first step is ignored
   always_comb begin
      nxt = state;
      case (state)
         S_IDLE:   nxt = start ? S_LOAD : S_IDLE;
         S_LOAD:   nxt = max_q == '0 ? S_DONE : S_STEP;
         S_STEP:   nxt = S_CHECK;
         S_CHECK:  nxt = (step_cnt >= 2 && same) ? S_PSTEP : step_cnt == max_q ? S_DONE : S_STEP;
         S_PSTEP:  nxt = S_PCHECK;
         S_PCHECK: nxt = (same || period_cnt == max_q) ? S_DONE : S_PSTEP;
         default:  nxt = S_IDLE;
      endcase
      if (abort) nxt = S_IDLE;
   end
   // state, registered strobes decoded from the next state, counters and held results
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         reset_nos  <= 1'b0;
         start_s0   <= 1'b0;
         start_s1   <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         found      <= 1'b0;
         init_state <= '0;
         meet_step  <= '0;
         period     <= '0;
         step_cnt   <= '0;
         period_cnt <= '0;
         max_q      <= '0;
      end else begin
         state     <= nxt;
         reset_nos <= nxt == S_LOAD;
         start_s0  <= nxt == S_STEP;
         start_s1  <= nxt == S_STEP || nxt == S_PSTEP;
         busy      <= nxt != S_IDLE;
         done      <= nxt == S_DONE;
         if (state == S_IDLE && nxt == S_LOAD) begin
            init_state <= init_value;
            max_q      <= max_steps;
            found      <= 1'b0;
            meet_step  <= '0;
            period     <= '0;
            step_cnt   <= '0;
            period_cnt <= '0;
         end
         if (state == S_STEP) step_cnt <= step_cnt + 1'b1;
         if (state == S_CHECK && nxt == S_PSTEP) begin
            meet_step  <= step_cnt;
            period_cnt <= '0;
         end
         if (state == S_PSTEP) period_cnt <= period_cnt + 1'b1;
         if (state == S_PCHECK && nxt == S_DONE && same) begin
            period <= period_cnt;
            found  <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_gnr_cycle_ctrl.sv
// tb_gnr_cycle_ctrl: drives runs against a 3-node rotate-left network and scores results at done
module tb_gnr_cycle_ctrl;
   localparam int N = 3;
   localparam int W = 32;
   logic clk = 1'b0, rst = 1'b0, start = 1'b0, abort = 1'b0;
   logic [N-1:0] init_value = '0;
   logic [W-1:0] max_steps = '0;
   logic [N-1:0] s0_vec, s1_vec, init_state;
   logic reset_nos, start_s0, start_s1, busy, done, found, pass;
   logic [W-1:0] meet_step, period;
   typedef struct {logic [N-1:0] init; logic found; logic [W-1:0] meet; logic [W-1:0] per; int n_rst; int n_s0; int n_s1; int cyc;} exp_t;
   exp_t q[$];
   exp_t e;
   int checks = 0, errors = 0, n_done = 0, cyc = 0, n_rst = 0, n_s0 = 0, n_s1 = 0;

   gnr_cycle_ctrl #(.NUM_NODES(N), .STEP_W(W)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .init_value(init_value),
      .max_steps(max_steps), .s0_vec(s0_vec), .s1_vec(s1_vec), .reset_nos(reset_nos),
      .init_state(init_state), .start_s0(start_s0), .start_s1(start_s1), .busy(busy),
      .done(done), .found(found), .meet_step(meet_step), .period(period)
   );

   always #5 clk = ~clk;

   function automatic logic [N-1:0] rotl(input logic [N-1:0] v);
      return {v[N-2:0], v[N-1]};
   endfunction

   function automatic exp_t mk(input logic [N-1:0] init, input logic f, input int m, input int p,
                               input int nr, input int n0, input int n1, input int c);
      exp_t x;
      x.init = init; x.found = f; x.meet = W'(m); x.per = W'(p);
      x.n_rst = nr; x.n_s0 = n0; x.n_s1 = n1; x.cyc = c;
      return x;
   endfunction

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // node array: s0 moves on every other start_s0 (first pulse moves), s1 on every start_s1
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         s0_vec <= '0; s1_vec <= '0; pass <= 1'b0;
      end else if (reset_nos) begin
         s0_vec <= init_state; s1_vec <= init_state; pass <= 1'b0;
      end else begin
         if (start_s0) begin
            if (!pass) s0_vec <= rotl(s0_vec);
            pass <= ~pass;
         end
         if (start_s1) s1_vec <= rotl(s1_vec);
      end
   end

   // per-run pulse/cycle counting and scoreboard pop at done
   always @(negedge clk) begin
      if (rst) begin
         if (!busy) begin
            cyc = 0; n_rst = 0; n_s0 = 0; n_s1 = 0;
         end else begin
            cyc++;
            n_rst += int'(reset_nos);
            n_s0 += int'(start_s0);
            n_s1 += int'(start_s1);
            if (done) begin
               n_done++;
               if (q.size() == 0) chk("unexpected_done", 1, 0);
               else begin
                  e = q.pop_front();
                  chk("found", found, e.found);
                  chk("meet_step", meet_step, e.meet);
                  chk("period", period, e.per);
                  chk("init_state", init_state, e.init);
                  chk("reset_nos_pulses", n_rst, e.n_rst);
                  chk("start_s0_pulses", n_s0, e.n_s0);
                  chk("start_s1_pulses", n_s1, e.n_s1);
                  chk("cycles_to_done", cyc, e.cyc);
               end
            end
         end
      end
   end

   task automatic launch(input logic [N-1:0] iv, input int ms, input exp_t x, input bit push);
      @(negedge clk);
      init_value = iv; max_steps = W'(ms); start = 1'b1;
      if (push) q.push_back(x);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int d0 = n_done;
      bit ok = 1'b0;
      repeat (300) begin
         @(negedge clk); #1;
         if (n_done != d0) begin ok = 1'b1; break; end
      end
      chk({tag, "_done_seen"}, ok, 1);
   endtask

   initial begin
      int d0;
      bit seen;
      #12;
      chk("reset_outputs", {reset_nos, init_state, start_s0, start_s1, busy, done, found, meet_step, period}, 0);
      @(negedge clk) rst = 1'b1;
      @(negedge clk);
      chk("idle_busy", busy, 0);
      launch(3'b001, 100, mk(3'b001, 1, 6, 3, 1, 6, 9, 20), 1);
      wait_done("rotate");
      launch(3'b000, 100, mk(3'b000, 1, 2, 1, 1, 2, 3, 8), 1);
      wait_done("fixed_point");
      launch(3'b001, 3, mk(3'b001, 0, 0, 0, 1, 3, 3, 8), 1);
      wait_done("timeout");
      launch(3'b101, 0, mk(3'b101, 0, 0, 0, 1, 0, 0, 2), 1);
      wait_done("zero_budget");
      launch(3'b001, 100, e, 0);
      seen = 1'b0;
      repeat (100) begin
         @(negedge clk);
         if (start_s1 && !start_s0) begin seen = 1'b1; break; end
      end
      chk("reach_pstep", seen, 1);
      abort = 1'b1;
      d0 = n_done;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_outputs", {busy, reset_nos, start_s0, start_s1, done}, 0);
      chk("abort_found", found, 0);
      repeat (30) @(negedge clk);
      chk("abort_no_done", n_done, d0);
      launch(3'b001, 100, mk(3'b001, 1, 6, 3, 1, 6, 9, 20), 1);
      wait_done("after_abort");
      launch(3'b001, 100, e, 0);
      seen = 1'b0;
      repeat (100) begin
         @(negedge clk);
         if (start_s0) begin seen = 1'b1; break; end
      end
      chk("reach_step", seen, 1);
      rst = 1'b0;
      #1;
      chk("async_reset_outputs", {reset_nos, init_state, start_s0, start_s1, busy, done, found, meet_step, period}, 0);
      @(negedge clk) rst = 1'b1;
      @(negedge clk);
      init_value = 3'b000; max_steps = W'(100); start = 1'b1;
      q.push_back(mk(3'b000, 1, 2, 1, 1, 2, 3, 8));
      q.push_back(mk(3'b000, 1, 2, 1, 1, 2, 3, 8));
      wait_done("held_start_first");
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (reset_nos) begin seen = 1'b1; break; end
      end
      chk("second_start_accepted", seen, 1);
      start = 1'b0;
      wait_done("held_start_second");
      chk("queue_empty", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
